dot_mac: RTL and testbench

- Downstream consumer of a pair of delay-buffer FIFOs: one holds a row vector (A), one holds a column vector (B).
- On `start`, the block drives the shared shift enable for DEPTH cycles and reads one A/B element pair per cycle.
- Each pair goes through a registered signed multiply, and the products are accumulated into a dot product.
- The result is presented with a one-cycle valid pulse; this is the MAC stage of the matrix-multiply datapath.

---
 rtl/dot_mac_pkg.sv | 17 +
 rtl/dot_mac_mul.sv | 33 +++
 rtl/dot_mac.sv | 130 +++++++++++++
 tb/tb_dot_mac.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_mac_pkg.sv
// Shared types and helpers for the dot_mac MAC stage.
// Optional build macro DOT_MAC_SATURATE_EN (used in dot_mac.sv) selects saturating accumulation.
package dot_mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Width of the element counter; never narrower than one bit.
    function automatic int cnt_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dot_mac_mul.sv
// Registered signed multiplier with a matching valid flag.
// Kept separate so it can later become a deeper pipeline without touching the accumulator.
module dot_mac_mul
    import dot_mac_pkg::*;
#(
    parameter int BITS_AB = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic signed [BITS_AB-1:0]     a,
    input  logic signed [BITS_AB-1:0]     b,
    input  logic                          vld_in,
    output logic signed [2*BITS_AB-1:0]   p,
    output logic                          vld_out
);

    logic signed [2*BITS_AB-1:0] r_p;
    logic                        r_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p   <= '0;
            r_vld <= 1'b0;
        end else begin
            r_p   <= a * b;
            r_vld <= vld_in;
        end
    end

    assign p       = r_p;
    assign vld_out = r_vld;

endmodule

// File: rtl/dot_mac.sv
// Dot-product MAC: streams DEPTH A/B pairs from the upstream FIFOs and accumulates their products.
// Build macro DOT_MAC_SATURATE_EN: accumulation clamps to the signed BITS_C range instead of wrapping.
module dot_mac
    import dot_mac_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int BITS_AB = 8,
    parameter int BITS_C  = 24
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic signed [BITS_AB-1:0]  a_in,
    input  logic signed [BITS_AB-1:0]  b_in,
    output logic                       fifo_en,
    output logic                       busy,
    output logic signed [BITS_C-1:0]   c_out,
    output logic                       c_valid
);

    localparam int CNT_W = cnt_width(DEPTH);
    localparam int P_W   = 2 * BITS_AB;

    generate
        if (BITS_C < 2 * BITS_AB) begin : g_bad_width
            $error("dot_mac: BITS_C must be at least 2*BITS_AB");
        end
        if (DEPTH < 2) begin : g_bad_depth
            $error("dot_mac: DEPTH must be at least 2");
        end
    endgenerate

    state_t                   r_state;
    state_t                   w_state_next;
    logic [CNT_W-1:0]         r_count;
    logic [CNT_W-1:0]         w_count_next;
    logic signed [P_W-1:0]    w_p;
    logic                     w_p_vld;
    logic signed [BITS_C-1:0] r_acc;
    logic signed [BITS_C-1:0] w_acc_next;
    logic signed [BITS_C-1:0] w_acc_add;
    logic signed [BITS_C-1:0] w_p_ext;
    logic signed [BITS_C-1:0] w_sum;
    logic signed [BITS_C-1:0] r_c_out;

    dot_mac_mul #(
        .BITS_AB (BITS_AB)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a_in),
        .b       (b_in),
        .vld_in  (fifo_en),
        .p       (w_p),
        .vld_out (w_p_vld)
    );

    assign w_p_ext = BITS_C'(w_p);
    assign w_sum   = r_acc + w_p_ext;

`ifdef DOT_MAC_SATURATE_EN
    localparam logic signed [BITS_C-1:0] ACC_MAX = {1'b0, {(BITS_C-1){1'b1}}};
    localparam logic signed [BITS_C-1:0] ACC_MIN = {1'b1, {(BITS_C-1){1'b0}}};

    logic w_ovf_pos;
    logic w_ovf_neg;

    // Overflow only when both operands share a sign that the sum does not.
    assign w_ovf_pos = !r_acc[BITS_C-1] && !w_p_ext[BITS_C-1] &&  w_sum[BITS_C-1];
    assign w_ovf_neg =  r_acc[BITS_C-1] &&  w_p_ext[BITS_C-1] && !w_sum[BITS_C-1];
    assign w_acc_add = w_ovf_pos ? ACC_MAX : (w_ovf_neg ? ACC_MIN : w_sum);
`else
    assign w_acc_add = w_sum;
`endif

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = LOAD;
                end
            end
            LOAD: begin
                if (r_count == CNT_W'(DEPTH - 1)) begin
                    w_state_next = DRAIN;
                    w_count_next = '0;
                end else begin
                    w_count_next = r_count + CNT_W'(1);
                end
            end
            DRAIN:   w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_acc_next = r_acc;
        if (r_state == IDLE && start) begin
            w_acc_next = '0;
        end else if (w_p_vld) begin
            w_acc_next = w_acc_add;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_count <= '0;
            r_acc   <= '0;
            r_c_out <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_acc   <= w_acc_next;
            // The last product lands during DRAIN, so capture the post-add value.
            if (r_state == DRAIN) begin
                r_c_out <= w_acc_next;
            end
        end
    end

    assign fifo_en = (r_state == LOAD);
    assign busy    = (r_state != IDLE);
    assign c_valid = (r_state == DONE);
    assign c_out   = r_c_out;

endmodule

// File: tb/tb_dot_mac.sv
// Scoreboard bench for dot_mac: a 24-bit and a 16-bit accumulator instance see identical stimulus.
// Expected sums come from a plain-arithmetic model (wrap or clamp per DOT_MAC_SATURATE_EN).
module tb_dot_mac;

    localparam int DEPTH = 8;
    localparam int BAB   = 8;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b1;
    logic                   start = 1'b0;
    logic signed [BAB-1:0]  a_in = '0;
    logic signed [BAB-1:0]  b_in = '0;
    logic                   fifo_en24, busy24, c_valid24;
    logic                   fifo_en16, busy16, c_valid16;
    logic signed [23:0]     c_out24;
    logic signed [15:0]     c_out16;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dot_mac #(.DEPTH(DEPTH), .BITS_AB(BAB), .BITS_C(24)) u_dut24 (
        .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
        .fifo_en(fifo_en24), .busy(busy24), .c_out(c_out24), .c_valid(c_valid24)
    );

    dot_mac #(.DEPTH(DEPTH), .BITS_AB(BAB), .BITS_C(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
        .fifo_en(fifo_en16), .busy(busy16), .c_out(c_out16), .c_valid(c_valid16)
    );

    // Bench-side model state
    int                     m_busy = 0;    // cycles of busy remaining, counting the current one
    int                     cur_mode = 0;
    logic signed [BAB-1:0]  a_q[$];
    logic signed [BAB-1:0]  b_q[$];
    longint                 sb24[$];
    longint                 sb16[$];
    longint                 last24 = 0;
    longint                 last16 = 0;
    bit                     mon_en = 1'b0;

    task automatic chk(input string name, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d at t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic longint acc_step(input longint s, input longint prod, input int w);
        longint v;
        longint lim;
        v   = s + prod;
        lim = longint'(1) <<< (w - 1);
`ifdef DOT_MAC_SATURATE_EN
        if (v > lim - 1) v = lim - 1;
        if (v < -lim)    v = -lim;
`else
        v = v & ((longint'(1) <<< w) - 1);
        if (v >= lim) v = v - (longint'(1) <<< w);
`endif
        return v;
    endfunction

    function automatic logic signed [BAB-1:0] gen_a(input int mode, input int i);
        case (mode)
            1:       return BAB'(i + 1);
            2:       return -8'sd1;
            3:       return 8'sd3;
            4:       return 8'sd127;
            5:       return 8'sd2;
            6:       return 8'sd0;
            default: return BAB'($urandom);
        endcase
    endfunction

    function automatic logic signed [BAB-1:0] gen_b(input int mode);
        case (mode)
            1:       return 8'sd1;
            2:       return 8'sd2;
            3:       return 8'sd3;
            4:       return 8'sd127;
            5:       return 8'sd5;
            default: return BAB'($urandom);
        endcase
    endfunction

    // An accepted start: load the upstream FIFO model and predict both results.
    task automatic load_op();
        longint s24 = 0;
        longint s16 = 0;
        logic signed [BAB-1:0] a, b;
        for (int i = 0; i < DEPTH; i++) begin
            a = gen_a(cur_mode, i);
            b = gen_b(cur_mode);
            a_q.push_back(a);
            b_q.push_back(b);
            s24 = acc_step(s24, longint'(a) * longint'(b), 24);
            s16 = acc_step(s16, longint'(a) * longint'(b), 16);
        end
        sb24.push_back(s24);
        sb16.push_back(s16);
        m_busy = DEPTH + 2;
    endtask

    task automatic cycle();
        bit take;
        take = start && (m_busy == 0) && rst_n;
        @(posedge clk);
        if (take) load_op();
        else if (m_busy > 0) m_busy--;
        #1;
        if (m_busy >= 3 && a_q.size() > 0) begin
            a_in = a_q.pop_front();
            b_in = b_q.pop_front();
        end else begin
            a_in = BAB'($urandom);
            b_in = BAB'($urandom);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic pulse(input int mode);
        cur_mode = mode;
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && m_busy != 0; i++) cycle();
        cycle();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        start = 1'b0;
        m_busy = 0;
        a_q.delete();
        b_q.delete();
        sb24.delete();
        sb16.delete();
        last24 = 0;
        last16 = 0;
        run(2);
        rst_n = 1'b1;
    endtask

    // Monitor: protocol checks every cycle, results popped whenever the DUT flags c_valid.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("fifo_en24", fifo_en24, m_busy >= 3);
            chk("fifo_en16", fifo_en16, m_busy >= 3);
            chk("busy24", busy24, m_busy != 0);
            chk("busy16", busy16, m_busy != 0);
            chk("c_valid24", c_valid24, m_busy == 1);
            chk("c_valid16", c_valid16, m_busy == 1);
            if (c_valid24) begin
                if (sb24.size() == 0) chk("c_out24_unexpected", 1, 0);
                else begin
                    last24 = sb24.pop_front();
                    chk("c_out24", longint'(c_out24), last24);
                    $display("result24 c_out=%0d expected=%0d t=%0t", c_out24, last24, $time);
                end
            end else begin
                chk("c_out24_hold", longint'(c_out24), last24);
            end
            if (c_valid16) begin
                if (sb16.size() == 0) chk("c_out16_unexpected", 1, 0);
                else begin
                    last16 = sb16.pop_front();
                    chk("c_out16", longint'(c_out16), last16);
                    $display("result16 c_out=%0d expected=%0d t=%0t", c_out16, last16, $time);
                end
            end else begin
                chk("c_out16_hold", longint'(c_out16), last16);
            end
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        mon_en = 1'b1;
        run(2);
        rst_n = 1'b1;
        run(2);

        // Ramp 1..8 times 1 -> 36
        pulse(1);
        wait_idle();
        // -1 x 2 -> -16
        pulse(2);
        wait_idle();
        // start held high: back-to-back results of 72, interval DEPTH+3
        cur_mode = 3;
        start = 1'b1;
        run(30);
        start = 1'b0;
        wait_idle();
        // 127*127 x8: wraps (or clamps) in the 16-bit instance
        pulse(4);
        wait_idle();
        // Reset in the middle of LOAD, then a clean 2*5 op -> 80
        pulse(1);
        run(3);
        apply_reset();
        run(2);
        pulse(5);
        wait_idle();
        // 36 then an all-zero-A op; c_out must hold 36 until the second result
        pulse(1);
        wait_idle();
        pulse(6);
        wait_idle();

        // Random traffic with start requests arriving while busy
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 4))
                0:       cur_mode = 4;
                1:       cur_mode = 6;
                default: cur_mode = 0;
            endcase
            start = ($urandom_range(0, 2) == 0);
            cycle();
        end
        start = 1'b0;
        wait_idle();
        run(2);

        chk("sb24_drained", sb24.size(), 0);
        chk("sb16_drained", sb16.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
